// File: rtl/memory_arbiter_pkg.sv
// Shared CPU memory types plus the arbiter's FSM state and grant encodings.
package memory_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates the icache read port and dcache read/write port onto the single RAM port.
// Optional: define MEM_ARB_RETRY_EN to re-issue accesses that end in ERROR up to RETRY_MAX times.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ram_err
);

    arb_state_t state, state_n;
    grant_t     last_grant, last_grant_n;
    logic       d_req;
    logic       serve_d;
    logic       req_live;
    logic       strobe_en;
    logic       complete;

`ifdef MEM_ARB_RETRY_EN
    localparam int unsigned RCW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    logic [RCW-1:0] retry_cnt, retry_n;
    logic           rearm, rearm_n;
`else
    // RETRY_MAX only has meaning when retries are built in
    logic unused_retry_max;
    assign unused_retry_max = |32'(RETRY_MAX);
`endif

    assign d_req = dREN | dWEN;

    // Grant decision, RAM port mux and completion handshake
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        ram_err      = 1'b0;
        serve_d      = (state == DSERV);
        req_live     = serve_d ? d_req : iREN;
        strobe_en    = 1'b0;
        complete     = 1'b0;
`ifdef MEM_ARB_RETRY_EN
        retry_n      = retry_cnt;
        rearm_n      = 1'b0;
`endif
        if (state == IDLE) begin
            if (d_req && (!iREN || last_grant == GRANT_I)) begin
                state_n = DSERV;
            end else if (iREN) begin
                state_n = ISERV;
            end
        end else if (!req_live) begin
            // requester withdrew: abort without completion
            state_n = IDLE;
`ifdef MEM_ARB_RETRY_EN
            retry_n = '0;
`endif
        end else begin
`ifdef MEM_ARB_RETRY_EN
            strobe_en = ~rearm;
`else
            strobe_en = 1'b1;
`endif
            ramaddr  = serve_d ? daddr : iaddr;
            ramstore = serve_d ? dstore : '0;
            ramWEN   = strobe_en & serve_d & dWEN;
            ramREN   = strobe_en & (serve_d ? (dREN & ~dWEN) : 1'b1);

            if (strobe_en && ramstate == ACCESS) begin
                complete = 1'b1;
            end
            if (strobe_en && ramstate == ERROR) begin
`ifdef MEM_ARB_RETRY_EN
                if (retry_cnt < RCW'(RETRY_MAX)) begin
                    rearm_n = 1'b1;
                    retry_n = retry_cnt + RCW'(1);
                end else begin
                    complete = 1'b1;
                    ram_err  = 1'b1;
                end
`else
                complete = 1'b1;
                ram_err  = 1'b1;
`endif
            end

            if (complete) begin
                state_n      = IDLE;
                last_grant_n = serve_d ? GRANT_D : GRANT_I;
`ifdef MEM_ARB_RETRY_EN
                retry_n      = '0;
`endif
                if (serve_d) begin
                    dwait = 1'b0;
                    dload = ramload;
                end else begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
        end
    end

`ifdef MEM_ARB_RETRY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            retry_cnt <= '0;
            rearm     <= 1'b0;
        end else begin
            retry_cnt <= retry_n;
            rearm     <= rearm_n;
        end
    end
`endif

endmodule
